// File: rtl/tc_prog_arb_pkg.sv
// ---------------------------------------------------------------------------
// tc_prog_arb_pkg
// Shared types and constants for the program-ROM fetch arbiter:
//   state_e  : arbiter sequencing states (IDLE -> RUN -> RESP -> IDLE)
//   req_id_e : requester identifiers (instruction fetch F, data load D)
//   LEN_W    : width of the request length field (byte count minus 1)
//   BYTE_W   : width of one ROM word
// ---------------------------------------------------------------------------
package tc_prog_arb_pkg;

  localparam int LEN_W  = 2;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

endpackage

// File: rtl/tc_prog_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tc_prog_rr_arbiter
// Two-way round-robin arbiter. When enabled, grants the sole valid requester,
// or, when both are valid, the one that was not granted last. The
// last-granted record only moves when the grant is actually taken (advance).
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   valid_i    in   [1:0] request valids, bit index = req_id_e
//   enable_i   in   arbitration allowed this cycle
//   advance_i  in   the current grant is being accepted
//   grant_o    out  [1:0] one-hot grant (all zero when disabled / no valid)
//   last_o     out  registered last-granted requester
// ---------------------------------------------------------------------------
module tc_prog_rr_arbiter
  import tc_prog_arb_pkg::*;
#(
  parameter int RESET_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       enable_i,
  input  logic       advance_i,
  output logic [1:0] grant_o,
  output req_id_e    last_o
);

  req_id_e last_q, last_d;

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (last_q == REQ_F) ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance_i) begin
      if (grant_o[1]) begin
        last_d = REQ_D;
      end else if (grant_o[0]) begin
        last_d = REQ_F;
      end
    end
  end

  // Reset records the non-priority requester as last granted so that the
  // priority requester wins the first contested cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= (RESET_PRIO == 0) ? REQ_D : REQ_F;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/tc_program_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tc_program_fetch_arbiter
// Shares one byte-wide program ROM with a one-cycle registered read between
// the instruction-fetch (F) and data-load (D) requesters. A request is a base
// address plus 1..MAX_BYTES bytes; the block issues one ROM address per cycle
// and assembles a little-endian word (byte k = mem[base+k], upper bytes 0).
//
// Optional feature (macro TC_PROG_ARB_WRAP_ERR_EN):
//   defined     : a request whose last byte would pass 16'hFFFF is answered in
//                 the cycle after accept with rsp_err=1, rsp_data=0 and no
//                 ROM reads.
//   not defined : addresses wrap modulo 2^ADDR_W; rsp_err is constant 0.
//
// Ports (x = f or d)
//   clk, rst          clock, synchronous active-high reset
//   x_req_valid/ready request handshake; x_req_addr base, x_req_len bytes-1
//   x_rsp_valid/ready response handshake; x_rsp_data assembled data
//   x_rsp_err         wrap error flag
//   rom_address       ROM address (0 outside RUN)
//   rom_out           ROM data for the address presented the previous cycle
// ---------------------------------------------------------------------------
module tc_program_fetch_arbiter
  import tc_prog_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MAX_BYTES  = 4,
  parameter int RESET_PRIO = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        f_req_valid,
  output logic                        f_req_ready,
  input  logic [ADDR_W-1:0]           f_req_addr,
  input  logic [LEN_W-1:0]            f_req_len,
  output logic                        f_rsp_valid,
  input  logic                        f_rsp_ready,
  output logic [BYTE_W*MAX_BYTES-1:0] f_rsp_data,
  output logic                        f_rsp_err,
  input  logic                        d_req_valid,
  output logic                        d_req_ready,
  input  logic [ADDR_W-1:0]           d_req_addr,
  input  logic [LEN_W-1:0]            d_req_len,
  output logic                        d_rsp_valid,
  input  logic                        d_rsp_ready,
  output logic [BYTE_W*MAX_BYTES-1:0] d_rsp_data,
  output logic                        d_rsp_err,
  output logic [ADDR_W-1:0]           rom_address,
  input  logic [BYTE_W-1:0]           rom_out
);

  localparam int DATA_W = BYTE_W * MAX_BYTES;
  localparam int CNT_W  = $clog2(MAX_BYTES + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [1:0]          grant;
  req_id_e             owner;
  logic                arb_en;
  logic                accept;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;
  logic                wrap_hit;
  logic                rsp_fire;
  logic [CNT_W-1:0]    last_cnt;

  // Arbitration only in IDLE; gating with rst keeps both readies low while
  // reset is asserted.
  assign arb_en = (state_q == IDLE) && !rst;

  tc_prog_rr_arbiter #(
    .RESET_PRIO (RESET_PRIO)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid_i   ({d_req_valid, f_req_valid}),
    .enable_i  (arb_en),
    .advance_i (accept),
    .grant_o   (grant),
    .last_o    (owner)
  );

  // A grant is only issued to a valid requester, so a grant is an accept.
  // After accept the arbiter's last-granted register names the transfer owner.
  assign accept      = |grant;
  assign f_req_ready = grant[0];
  assign d_req_ready = grant[1];
  assign sel_addr    = grant[1] ? d_req_addr : f_req_addr;
  assign sel_len     = grant[1] ? d_req_len  : f_req_len;

`ifdef TC_PROG_ARB_WRAP_ERR_EN
  logic err_q, err_d;

  // base+len overflows exactly when base exceeds all-ones minus len.
  assign wrap_hit = (sel_addr > ({ADDR_W{1'b1}} - ADDR_W'(sel_len)));

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = wrap_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign f_rsp_err = f_rsp_valid & err_q;
  assign d_rsp_err = d_rsp_valid & err_q;
`else
  assign wrap_hit  = 1'b0;
  assign f_rsp_err = 1'b0;
  assign d_rsp_err = 1'b0;
`endif

  assign rsp_fire = (state_q == RESP) &&
                    ((owner == REQ_F) ? f_rsp_ready : d_rsp_ready);

  // RUN lasts len+2 cycles: cnt 0..len present addresses, cnt 1..len+1
  // capture the byte requested one cycle earlier.
  assign last_cnt = CNT_W'(len_q) + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = sel_addr;
          len_d   = sel_len;
          data_d  = '0;
          cnt_d   = '0;
          state_d = wrap_hit ? RESP : RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int b = 0; b < MAX_BYTES; b++) begin
          if (cnt_q == CNT_W'(b + 1)) begin
            data_d[b*BYTE_W +: BYTE_W] = rom_out;
          end
        end
        if (cnt_q == last_cnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --- control registers (reset) ---
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --- datapath registers (no reset; outputs are gated by state) ---
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    len_q  <= len_d;
    data_q <= data_d;
  end

  assign f_rsp_valid = (state_q == RESP) && (owner == REQ_F);
  assign d_rsp_valid = (state_q == RESP) && (owner == REQ_D);
  assign f_rsp_data  = f_rsp_valid ? data_q : '0;
  assign d_rsp_data  = d_rsp_valid ? data_q : '0;

  assign rom_address = ((state_q == RUN) && (cnt_q <= CNT_W'(len_q)))
                       ? (addr_q + ADDR_W'(cnt_q)) : '0;

endmodule

// File: tb/tb_tc_program_fetch_arbiter.sv
module tb_tc_program_fetch_arbiter;

`ifdef TC_PROG_ARB_WRAP_ERR_EN
  localparam bit WRAP_ERR = 1'b1;
`else
  localparam bit WRAP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req_valid, f_req_ready, d_req_valid, d_req_ready;
  logic [15:0] f_req_addr, d_req_addr;
  logic [1:0]  f_req_len, d_req_len;
  logic        f_rsp_valid, f_rsp_ready, d_rsp_valid, d_rsp_ready;
  logic [31:0] f_rsp_data, d_rsp_data;
  logic        f_rsp_err, d_rsp_err;
  logic [15:0] rom_address;
  logic [7:0]  rom_out;

  always #5 clk = ~clk;

  tc_program_fetch_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready),
    .f_req_addr(f_req_addr), .f_req_len(f_req_len),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready),
    .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_req_addr(d_req_addr), .d_req_len(d_req_len),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
    .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .rom_address(rom_address), .rom_out(rom_out)
  );

  // Program ROM with one-cycle registered read
  logic [7:0] mem [0:65535];
  always @(posedge clk) rom_out <= mem[rom_address];

  int   cyc = 0;
  logic rst_d1 = 1'b0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_d1 <= rst;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { logic [15:0] addr; logic [1:0] len; } req_t;
  typedef struct { bit id; logic [31:0] data; bit err; int due; } exp_t;

  req_t f_pend[$], d_pend[$];
  exp_t exp_q[$];

  // Reference: byte k of the answer is mem[(addr+k) mod 2^16], upper bytes 0.
  function automatic logic [31:0] ref_data(input logic [15:0] addr, input int len);
    logic [31:0] r = '0;
    for (int k = 0; k <= len; k++) r[k*8 +: 8] = mem[16'(int'(addr) + k)];
    return r;
  endfunction

  // ---------------- request / response-ready drivers ----------------
  bit f_fire, d_fire;
  int f_rdy_mode = 2, d_rdy_mode = 2;  // 0 random, 1 hold low, 2 always high

  always @(negedge clk) begin
    f_fire = f_req_valid & f_req_ready;
    d_fire = d_req_valid & d_req_ready;
  end

  initial begin
    req_t r;
    forever begin
      @(posedge clk); #1;
      if (f_fire) f_req_valid = 1'b0;
      if (!f_req_valid && f_pend.size() > 0) begin
        r = f_pend.pop_front();
        f_req_addr = r.addr; f_req_len = r.len; f_req_valid = 1'b1;
      end
    end
  end

  initial begin
    req_t r;
    forever begin
      @(posedge clk); #1;
      if (d_fire) d_req_valid = 1'b0;
      if (!d_req_valid && d_pend.size() > 0) begin
        r = d_pend.pop_front();
        d_req_addr = r.addr; d_req_len = r.len; d_req_valid = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      f_rsp_ready = (f_rdy_mode == 2) ? 1'b1 : (f_rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      d_rsp_ready = (d_rdy_mode == 2) ? 1'b1 : (d_rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- transaction-level reference model ----------------
  bit          m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1, m_err = 1'b0;
  int          m_acc = 0, m_len = 0, m_due = 0;
  logic [15:0] m_addr = '0;

  always @(negedge clk) begin
    logic [1:0]  exp_rdy;
    logic [15:0] exp_rom;
    bit          done_now, wrap;
    exp_t        e;
    if (rst_d1) begin
      m_busy = 1'b0; m_last = 1'b1; exp_q.delete();
    end
    if (!(rst && !rst_d1)) begin
      exp_rom = '0;
      if (m_busy && !m_err && cyc >= m_acc + 1 && cyc <= m_acc + 1 + m_len)
        exp_rom = 16'(int'(m_addr) + (cyc - m_acc - 1));
      check(rom_address == exp_rom, "rom_address", rom_address, exp_rom);

      done_now = m_busy && cyc >= m_due && (m_owner ? d_rsp_ready : f_rsp_ready);

      exp_rdy = 2'b00;
      if (!rst && !m_busy) begin
        if (f_req_valid && d_req_valid) exp_rdy = m_last ? 2'b01 : 2'b10;
        else if (f_req_valid)           exp_rdy = 2'b01;
        else if (d_req_valid)           exp_rdy = 2'b10;
      end
      check({d_req_ready, f_req_ready} == exp_rdy, "req_ready",
            {d_req_ready, f_req_ready}, exp_rdy);

      if (exp_rdy != 2'b00) begin
        m_owner = exp_rdy[1];
        m_last  = m_owner;
        m_acc   = cyc;
        m_addr  = m_owner ? d_req_addr : f_req_addr;
        m_len   = int'(m_owner ? d_req_len : f_req_len);
        wrap    = (int'(m_addr) + m_len) > 65535;
        m_err   = WRAP_ERR && wrap;
        m_due   = m_err ? m_acc + 1 : m_acc + m_len + 3;
        m_busy  = 1'b1;
        e.id = m_owner; e.err = m_err; e.due = m_due;
        e.data = m_err ? 32'h0 : ref_data(m_addr, m_len);
        exp_q.push_back(e);
      end
      if (done_now) m_busy = 1'b0;
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  bit          holding = 1'b0;
  exp_t        cur;

  always @(negedge clk) begin
    bit          id;
    logic [31:0] obs;
    bit          oerr;
    if (rst_d1) begin
      holding = 1'b0;
      check({f_rsp_valid, d_rsp_valid, f_rsp_err, d_rsp_err} == 4'b0, "reset_rsp_ctl",
            {f_rsp_valid, d_rsp_valid, f_rsp_err, d_rsp_err}, 0);
      check(f_rsp_data == 32'h0 && d_rsp_data == 32'h0, "reset_rsp_data",
            f_rsp_data | d_rsp_data, 0);
    end else if (!rst) begin
      if (f_rsp_valid || d_rsp_valid) begin
        check(!(f_rsp_valid && d_rsp_valid), "one_rsp_valid", {f_rsp_valid, d_rsp_valid}, 1);
        id   = d_rsp_valid;
        obs  = id ? d_rsp_data : f_rsp_data;
        oerr = id ? d_rsp_err  : f_rsp_err;
        if (!holding) begin
          check(exp_q.size() != 0, "unexpected_rsp", obs, 0);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check(id == cur.id, "rsp_id", id, cur.id);
            check(obs == cur.data, "rsp_data", obs, cur.data);
            check(oerr == cur.err, "rsp_err", oerr, cur.err);
            check(cyc == cur.due, "rsp_cycle", cyc, cur.due);
            holding = 1'b1;
          end
        end else begin
          check(id == cur.id && obs == cur.data && oerr == cur.err, "rsp_hold", obs, cur.data);
        end
        if (id ? d_rsp_ready : f_rsp_ready) holding = 1'b0;
      end else if (holding) begin
        check(1'b0 == holding, "rsp_dropped", 0, 1);
        holding = 1'b0;
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        check(cyc <= exp_q[0].due, "rsp_late", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic push(input bit to_d, input logic [15:0] a, input logic [1:0] l);
    req_t r;
    r.addr = a; r.len = l;
    if (to_d) d_pend.push_back(r); else f_pend.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = f_pend.size() == 0 && d_pend.size() == 0 && !f_req_valid && !d_req_valid &&
             !m_busy && exp_q.size() == 0 && !holding;
    end
    check(done, "idle_timeout", exp_q.size(), 0);
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    f_req_addr = '0; d_req_addr = '0; f_req_len = '0; d_req_len = '0;
    f_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22;
    mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
    mem[16'h0100] = 8'hA5;

    repeat (5) step();
    rst = 1'b0;

    // single 4-byte fetch
    push(0, 16'h0010, 2'd3);
    wait_idle(100);

    // simultaneous F and D, twice: F, D, F, D
    push(0, 16'h0040, 2'd1); push(1, 16'h0080, 2'd2);
    push(0, 16'h0044, 2'd0); push(1, 16'h0084, 2'd3);
    wait_idle(200);

    // 1-byte D load with the response held off
    d_rdy_mode = 1;
    push(1, 16'h0100, 2'd0);
    repeat (10) step();
    d_rdy_mode = 2;
    wait_idle(100);

    // address wrap
    push(0, 16'hFFFE, 2'd3);
    wait_idle(100);

    // reset in the middle of RUN, then a clean request
    push(0, 16'h2000, 2'd3);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step();
      hit = m_busy && (cyc == m_acc + 2);
    end
    check(hit, "reach_run", 0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    push(0, 16'h3000, 2'd2);
    wait_idle(100);

    // randomized traffic
    f_rdy_mode = 0; d_rdy_mode = 0;
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        if (f_pend.size() < 2) push(0, a, 2'($urandom));
      end else begin
        if (d_pend.size() < 2) push(1, a, 2'($urandom));
      end
      repeat ($urandom_range(0, 4)) step();
    end
    f_rdy_mode = 2; d_rdy_mode = 2;
    wait_idle(5000);

    check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
